uart_tx_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART transmit frame engine between NUM_REQ byte producers.
- It accepts one byte from the winning requester and holds it. It offers the byte to the TX frame FSM over a valid/ready handshake, then locks out new grants until the FSM has finished the frame and returned to idle.
- It sits between the producer blocks and the TX frame FSM.

---
 rtl/uart_tx_arb.sv | 96 +++++++++
 tb/tb_uart_tx_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that feeds one shared UART TX frame engine.
// A granted byte is held, offered over valid/ready, and further grants are
// locked out until the frame engine has left idle and come back to it.
module uart_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_valid,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
  output logic                        busy,
  output logic [CNT_W-1:0]            frames_sent
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {ARB, OFFER, DRAIN, FRAME} state_t;

  state_t            state, next_state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win;
  logic              any;
  logic              grant;
  logic [DATA_W-1:0] hold_reg;

  // Rotating priority search starting just after the last winner; the
  // descending loop leaves the closest valid requester as the result.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        win = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
  end

  assign grant = (state == ARB) && any;

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ARB;
    else         state <= next_state;
  end

  // Next-state: OFFER waits for the handshake, DRAIN for the engine to leave
  // idle, FRAME for it to return to idle.
  always_comb begin
    next_state = state;
    case (state)
      ARB:     if (any)       next_state = OFFER;
      OFFER:   if (tx_ready)  next_state = DRAIN;
      DRAIN:   if (!tx_ready) next_state = FRAME;
      FRAME:   if (tx_ready)  next_state = ARB;
      default:                next_state = ARB;
    endcase
  end

  // Outputs decoded from state; the accept strobe is forced low while in reset.
  always_comb begin
    req_ready = '0;
    if (grant && arst_n) req_ready[win] = 1'b1;
    busy = (state != ARB);
  end

  // Grant capture, registered offer strobe and completed-frame counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      hold_reg    <= '0;
      gnt_id      <= '0;
      tx_valid    <= 1'b0;
      frames_sent <= '0;
    end else begin
      tx_valid <= (next_state == OFFER);
      if (grant) begin
        hold_reg <= req_data[int'(win)*DATA_W +: DATA_W];
        gnt_id   <= win;
        rr_ptr   <= win;
      end
      if (state == FRAME && tx_ready) frames_sent <= frames_sent + CNT_W'(1);
    end
  end

  // Held byte stays visible through the whole frame for the engine to sample.
  assign tx_data = hold_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed stimulus pushes expectations,
// a negedge monitor pops and compares as the DUT produces events.
module tb_uart_tx_arb;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int CW = 2;

  localparam int P_TXV = 0, P_TXD = 1, P_RDY = 2, P_GNT = 3, P_BUSY = 4, P_FS = 5;

  typedef struct packed { logic [1:0] id; logic [DW-1:0] d; } dexp_t;
  typedef struct { string name; int sig; logic [31:0] exp; } probe_t;

  logic             clk, arst_n;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DW-1:0] req_data;
  logic             tx_valid, tx_ready, busy;
  logic [DW-1:0]    tx_data;
  logic [1:0]       gnt_id;
  logic [CW-1:0]    frames_sent;

  uart_tx_arb #(.NUM_REQ(NR), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .gnt_id(gnt_id), .busy(busy), .frames_sent(frames_sent)
  );

  int     gq[$];
  dexp_t  dq[$];
  int     fq[$];
  probe_t pq[$];
  string  eq[$];

  int            n_cmp = 0, n_err = 0;
  logic          done = 1'b0, tmo = 1'b0;
  logic [NR-1:0] sticky, last_g;
  logic          force_busy;
  int            frame_len;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    tmo = 1'b1;
  end

  // TX frame engine model: idle = ready; after a handshake it goes busy for
  // frame_len cycles. force_busy holds it non-idle to create backpressure.
  initial begin
    logic hs;
    int   fcnt;
    tx_ready = 1'b1;
    fcnt = 0;
    forever begin
      @(negedge clk);
      hs = tx_valid && tx_ready;
      @(posedge clk);
      #2;
      if (hs) fcnt = frame_len;
      else if (fcnt > 0) fcnt--;
      tx_ready = (fcnt == 0) && !force_busy;
    end
  end

  function automatic logic [31:0] val(int s);
    case (s)
      P_TXV:   return 32'(tx_valid);
      P_TXD:   return 32'(tx_data);
      P_RDY:   return 32'(req_ready);
      P_GNT:   return 32'(gnt_id);
      P_BUSY:  return 32'(busy);
      default: return 32'(frames_sent);
    endcase
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", n, act, exp);
    end
  endtask

  task automatic unexpected(string n);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event seen, none expected", n);
  endtask

  // Monitor / scoreboard.
  initial begin
    logic [CW-1:0] prev_fs;
    int            e;
    dexp_t         de;
    probe_t        p;
    prev_fs = '0;
    forever begin
      @(negedge clk);
      while (pq.size() > 0) begin
        p = pq.pop_front();
        chk(p.name, val(p.sig), p.exp);
      end
      while (eq.size() > 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout want completion", eq.pop_front());
      end
      if (!arst_n) prev_fs = frames_sent;
      else begin
        if (req_ready != '0) begin
          if (gq.size() == 0) unexpected("grant");
          else begin
            e = gq.pop_front();
            chk("grant", 32'(req_ready), 32'(1) << e);
          end
        end
        if (tx_valid && tx_ready) begin
          if (dq.size() == 0) unexpected("handshake");
          else begin
            de = dq.pop_front();
            chk("tx_data", 32'(tx_data), 32'(de.d));
            chk("gnt_id", 32'(gnt_id), 32'(de.id));
          end
        end
        if (frames_sent != prev_fs) begin
          if (fq.size() == 0) unexpected("frames_sent");
          else begin
            e = fq.pop_front();
            chk("frames_sent", 32'(frames_sent), 32'(e));
          end
          prev_fs = frames_sent;
        end
      end
      if (done || tmo) begin
        if (tmo) begin
          n_cmp++;
          n_err++;
          $display("FAIL watchdog: got timeout want done");
        end
        chk("left_grants", 32'(gq.size()), 0);
        chk("left_data", 32'(dq.size()), 0);
        chk("left_frames", 32'(fq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    end
  end

  function automatic void probe(string n, int s, logic [31:0] e);
    pq.push_back('{n, s, e});
  endfunction

  function automatic void exp_frame(int id, logic [DW-1:0] d, int fs);
    gq.push_back(id);
    dq.push_back('{id[1:0], d});
    fq.push_back(fs);
  endfunction

  function automatic void probe_reset_vals();
    probe("rst_tx_valid", P_TXV, 0);
    probe("rst_tx_data", P_TXD, 0);
    probe("rst_gnt_id", P_GNT, 0);
    probe("rst_frames", P_FS, 0);
    probe("rst_req_ready", P_RDY, 0);
    probe("rst_busy", P_BUSY, 0);
  endfunction

  // One cycle: capture accept strobes at negedge, drop granted requests
  // (unless sticky) just after the edge.
  task automatic tick();
    @(negedge clk);
    last_g = req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(last_g & ~sticky);
  endtask

  task automatic wait_idle(string nm);
    for (int i = 0; i < 300; i++) begin
      if (!busy && req_valid == '0 && gq.size() == 0 && dq.size() == 0 && fq.size() == 0)
        return;
      tick();
    end
    eq.push_back(nm);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    arst_n = 1'b1; req_valid = '0; req_data = '0; sticky = '0; last_g = '0;
    force_busy = 1'b0; frame_len = 10;
    #1 arst_n = 1'b0;
    probe_reset_vals();
    tick();
    arst_n = 1'b1;

    // Single request
    req_data[0*DW +: DW] = 8'hA5;
    req_valid = 4'b0001;
    exp_frame(0, 8'hA5, 1);
    tick();
    probe("single_txv_c1", P_TXV, 1);
    probe("single_txd_c1", P_TXD, 32'hA5);
    tick();
    probe("single_txv_c2", P_TXV, 0);
    probe("single_busy_c2", P_BUSY, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      probe("single_busy_frame", P_BUSY, 1);
      tick();
    end
    wait_idle("single_idle");

    // Round robin from fresh reset; also walks the 2-bit counter through wrap
    do_reset();
    frame_len = 3;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(8'h10 + i);
    exp_frame(0, 8'h10, 1);
    exp_frame(1, 8'h11, 2);
    exp_frame(2, 8'h12, 3);
    exp_frame(3, 8'h13, 0);
    exp_frame(0, 8'h10, 1);
    sticky = 4'hF;
    req_valid = 4'hF;
    cnt = 0;
    for (int i = 0; i < 300 && cnt < 5; i++) begin
      tick();
      if (last_g != '0) cnt++;
    end
    if (cnt < 5) eq.push_back("rr_grants");
    sticky = '0;
    req_valid = '0;
    wait_idle("rr_idle");

    // Backpressure: engine not idle for 5 cycles of OFFER
    force_busy = 1'b1;
    req_data[3*DW +: DW] = 8'h5C;
    req_valid = 4'b1000;
    exp_frame(3, 8'h5C, 2);
    tick();
    for (int i = 0; i < 5; i++) begin
      probe("bp_txv", P_TXV, 1);
      probe("bp_txd", P_TXD, 32'h5C);
      tick();
    end
    force_busy = 1'b0;
    probe("bp_txv_hs", P_TXV, 1);
    tick();
    probe("bp_txv_after", P_TXV, 0);
    tick();
    wait_idle("bp_idle");

    // Reset in FRAME: byte discarded, requester 0 first afterwards
    frame_len = 8;
    req_data[1*DW +: DW] = 8'h77;
    req_valid = 4'b0010;
    gq.push_back(1);
    dq.push_back('{2'd1, 8'h77});
    tick();
    tick();
    tick();
    tick();
    req_data[0*DW +: DW] = 8'h01;
    req_data[3*DW +: DW] = 8'h0F;
    req_valid = 4'b1001;
    arst_n = 1'b0;
    probe_reset_vals();
    tick();
    arst_n = 1'b1;
    exp_frame(0, 8'h01, 1);
    exp_frame(3, 8'h0F, 2);
    wait_idle("rst_idle");

    // Lockout: requester 2 arrives mid-frame
    frame_len = 6;
    req_data[0*DW +: DW] = 8'h3C;
    req_valid = 4'b0001;
    exp_frame(0, 8'h3C, 3);
    tick();
    tick();
    req_data[2*DW +: DW] = 8'hC4;
    req_valid[2] = 1'b1;
    exp_frame(2, 8'hC4, 0);
    for (int i = 0; i < 7; i++) begin
      probe("lock_ready_low", P_RDY, 0);
      tick();
    end
    probe("lock_ready_2", P_RDY, 32'h4);
    tick();
    wait_idle("lock_idle");

    done = 1'b1;
  end

endmodule
